// File: rtl/seq_shift_left_unit.sv
// seq_shift_left_unit
//
// Multi-cycle logical left shifter. An operand and shift amount are captured
// when start is accepted in IDLE; the register then moves one bit position
// per clock and the last bit leaving the top position is kept in carry_out.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      request, sampled only in IDLE
//   data_in    operand, captured on accepted start
//   amount     shift count (0..2**CNT_W-1), captured on accepted start
//   rotate     (SHL_ROTATE_EN only) rotate-left select, captured on start
//   busy       high while shifting
//   done       one-cycle completion pulse
//   result     shift register contents, final when done=1, held afterwards
//   carry_out  last bit shifted out of bit WIDTH-1
//
// Build option: define SHL_ROTATE_EN to add the rotate input. With rotate=1
// the bit leaving the top re-enters at bit 0.
//
// state  | meaning
// -------+---------------------------------
// IDLE   | waiting for start
// SHIFT  | one shift per clock
// DONE   | single-cycle completion pulse

module seq_shift_left_unit #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic [CNT_W-1:0] amount,
`ifdef SHL_ROTATE_EN
    input  logic             rotate,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] shreg_q,  shreg_d;
    logic             carry_q,  carry_d;
    logic             fill;

`ifdef SHL_ROTATE_EN
    logic rot_q, rot_d;

    always_comb begin
        rot_d = rot_q;
        if (state_q == ST_IDLE && start) begin
            rot_d = rotate;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rot_q <= 1'b0;
        end else begin
            rot_q <= rot_d;
        end
    end

    assign fill = rot_q & shreg_q[WIDTH-1];
`else
    assign fill = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        carry_d = carry_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shreg_d = data_in;
                    cnt_d   = amount;
                    carry_d = 1'b0;
                    state_d = (amount == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shreg_d = {shreg_q[WIDTH-2:0], fill};
                carry_d = shreg_q[WIDTH-1];
                cnt_d   = cnt_q - 1'b1;
                // Leaving at count 1 means the counter never wraps below zero.
                if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            carry_q <= carry_d;
        end
    end

    assign busy      = (state_q == ST_SHIFT);
    assign done      = (state_q == ST_DONE);
    assign result    = shreg_q;
    assign carry_out = carry_q;

endmodule

// File: tb/tb_seq_shift_left_unit.sv
module tb_seq_shift_left_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [63:0] data_in;
    logic [5:0]  amount;
    logic        rotate;
    logic        busy;
    logic        done;
    logic [63:0] result;
    logic        carry_out;

    seq_shift_left_unit #(.WIDTH(64), .CNT_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .data_in   (data_in),
        .amount    (amount),
`ifdef SHL_ROTATE_EN
        .rotate    (rotate),
`endif
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        logic        cy;
        int          lat;
        int          acc_cyc;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   busy_cnt = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: pops an expectation whenever the DUT signals done.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk({e.name, "_result"}, result, e.res);
                    chk({e.name, "_carry"}, {63'd0, carry_out}, {63'd0, e.cy});
                    chk({e.name, "_latency"}, 64'(cyc - e.acc_cyc + 1), 64'(e.lat));
                    chk({e.name, "_busy_cycles"}, 64'(busy_cnt), 64'(e.lat - 1));
                end
                busy_cnt = 0;
            end
        end
    end

    // Issues one start at a negedge; the expectation is pushed with the
    // cycle index of the first cycle after the accepting edge.
    task automatic issue(input string name, input logic [63:0] d, input logic [5:0] a,
                         input logic rot, input logic push,
                         input logic [63:0] res, input logic cy);
        exp_t e;
        start   = 1'b1;
        data_in = d;
        amount  = a;
        rotate  = rot;
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        data_in = 64'h5A5A_5A5A_5A5A_5A5A;
        amount  = 6'd17;
        rotate  = ~rot;
        if (push) begin
            e.res = res; e.cy = cy; e.lat = int'(a) + 1; e.acc_cyc = cyc; e.name = name;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        #1;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (exp_q.size() != 0) begin
            chk({name, "_timeout"}, 64'd1, 64'd0);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b1;
        data_in = 64'hFFFF_FFFF_FFFF_FFFF;
        amount  = 6'd5;
        rotate  = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_result", result, 64'd0);
            chk("rst_carry", {63'd0, carry_out}, 64'd0);
            chk("rst_busy", {63'd0, busy}, 64'd0);
            chk("rst_done", {63'd0, done}, 64'd0);
        end
        start = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_idle_busy", {63'd0, busy}, 64'd0);
        chk("post_rst_idle_result", result, 64'd0);

        issue("basic", 64'h0000_0000_0000_0001, 6'd4, 1'b0, 1'b1, 64'h0000_0000_0000_0010, 1'b0);
        wait_drain("basic");
        repeat (3) @(negedge clk);
        chk("retain_result", result, 64'h0000_0000_0000_0010);
        chk("retain_busy", {63'd0, busy}, 64'd0);

        issue("carry", 64'h8000_0000_0000_0001, 6'd1, 1'b0, 1'b1, 64'h0000_0000_0000_0002, 1'b1);
        wait_drain("carry");
        repeat (2) @(negedge clk);
        chk("retain_carry", {63'd0, carry_out}, 64'd1);

        issue("zero_amt", 64'hDEAD_BEEF_0123_4567, 6'd0, 1'b0, 1'b1, 64'hDEAD_BEEF_0123_4567, 1'b0);
        wait_drain("zero_amt");

        issue("max_amt", 64'h8000_0000_0000_0001, 6'd63, 1'b0, 1'b1, 64'h8000_0000_0000_0000, 1'b0);
        wait_drain("max_amt");

        // Start pulsed mid-run must be ignored.
        issue("ignored_start", 64'h00F0_0000_0000_00A5, 6'd10, 1'b0, 1'b1, 64'hC000_0000_0002_9400, 1'b1);
        repeat (2) @(negedge clk);
        issue("ignored_pulse", 64'hFFFF_FFFF_FFFF_FFFF, 6'd1, 1'b0, 1'b0, 64'd0, 1'b0);
        wait_drain("ignored_start");

        // Reset abort in the third cycle of a run: no done may follow.
        issue("abort", 64'hFFFF_FFFF_FFFF_FFFF, 6'd8, 1'b0, 1'b0, 64'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_result", result, 64'd0);
        chk("abort_carry", {63'd0, carry_out}, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);

        issue("after_abort", 64'h0000_0000_0000_0001, 6'd2, 1'b0, 1'b1, 64'h0000_0000_0000_0004, 1'b0);
        wait_drain("after_abort");

`ifdef SHL_ROTATE_EN
        issue("rot_1", 64'h8000_0000_0000_0001, 6'd1, 1'b1, 1'b1, 64'h0000_0000_0000_0003, 1'b1);
        wait_drain("rot_1");
        issue("rot_63", 64'h8000_0000_0000_0001, 6'd63, 1'b1, 1'b1, 64'hC000_0000_0000_0000, 1'b0);
        wait_drain("rot_63");
        issue("rot_off", 64'h8000_0000_0000_0001, 6'd1, 1'b0, 1'b1, 64'h0000_0000_0000_0002, 1'b1);
        wait_drain("rot_off");
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_shift_left_unit.md
Name: seq_shift_left_unit

Overview:
- Multi-cycle 64-bit logical left shifter; the left-direction counterpart of the team's 1-bit combinational right shifter.
- Shifts a loaded operand left by a programmable amount (0..63), one bit position per clock, and reports the last bit shifted out.
- Feeds the sequential multiplier datapath and the ALU shift path through a start/busy/done handshake.

Parameters:
WIDTH, 64, operand/result width in bits
CNT_W, 6, shift-amount/counter width; must satisfy 2**CNT_W >= WIDTH

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
data_in  input  WIDTH  operand, captured when start is accepted
amount  input  CNT_W  shift count, captured when start is accepted
busy  output  1  high while in SHIFT
done  output  1  one-cycle completion pulse
result  output  WIDTH  shift register contents; final value valid when done=1
carry_out  output  1  last bit shifted out of bit WIDTH-1

Behaviour:
- Clocking and reset:
  - One clock domain: clk.
  - rst_n is asynchronous and active-low.
  - While rst_n=0: state=IDLE, result=0, carry_out=0, busy=0, done=0, counter=0.
- States:
  - IDLE: waiting for start.
  - SHIFT: one shift per cycle.
  - DONE: single-cycle completion.
- IDLE, start=1 at a rising edge (start accepted):
  - Load the register with data_in and the counter with amount.
  - Clear carry_out to 0.
  - Next state is DONE if amount==0, otherwise SHIFT.
- SHIFT, each edge:
  - reg <= {reg[WIDTH-2:0], fill}; fill=0 without the optional feature.
  - carry_out <= reg[WIDTH-1].
  - counter <= counter-1.
  - If counter==1 at that edge, next state is DONE.
- DONE: done=1 for exactly one cycle, then unconditional return to IDLE.
- Outputs:
  - busy = (state==SHIFT).
  - done = (state==DONE).
  - Both are decoded from registered state; there is no combinational path from start.
- Latency:
  - start accepted at edge 0 gives done high in cycle amount+1.
  - busy is high for exactly amount cycles.
- Result retention: result and carry_out hold their values after DONE until the next accepted start.
- start outside IDLE: start while in SHIFT or DONE is ignored and has no effect on the register, counter or outputs. The requester must re-assert start in IDLE, earliest the cycle after done.
- Input capture: data_in and amount are sampled only at acceptance; later changes to them are ignored.
- amount==0: operand passes unchanged, carry_out=0, done in the next cycle.
- Bit loss: bits shifted beyond WIDTH-1 are lost except the most recent one, which is in carry_out.
- Reset mid-operation: immediate clear to the reset values. No done pulse is produced for the aborted operation.
- Counter: does not wrap, because SHIFT exits at counter==1.

Optional Feature:
- Macro: SHL_ROTATE_EN.
- Defined:
  - Adds input port rotate (1 bit), captured with start.
  - If rotate=1, fill = reg[WIDTH-1], so the operation is rotate-left; carry_out still equals the bit leaving position WIDTH-1.
  - If rotate=0, behaviour is identical to the undefined case.
- Undefined: the rotate port does not exist and fill is always 0.

Test Plan:
- Reset: hold rst_n=0 three cycles with start=1 -> result=0, carry_out=0, busy=0, done=0 throughout. After release, no operation begins until start is sampled in IDLE.
- Basic shift: data_in=0x0000_0000_0000_0001, amount=4 -> busy high exactly cycles 1-4, done high in cycle 5 only, result=0x0000_0000_0000_0010, carry_out=0.
- Carry and zero amount:
  - data_in=0x8000_0000_0000_0001, amount=1 -> result=0x0000_0000_0000_0002, carry_out=1, done in cycle 2.
  - data_in=0xDEAD_BEEF_0123_4567, amount=0 -> done in cycle 1, result unchanged, carry_out=0, busy never high.
- Maximum amount: data_in=0x8000_0000_0000_0001, amount=63 -> done in cycle 64, result=0x8000_0000_0000_0000, carry_out=0.
- Ignored start, then reset abort:
  - During an amount=10 run, pulse start with data_in=0xFFFF_FFFF_FFFF_FFFF -> ignored; final result matches the original operand shifted by 10.
  - Assert rst_n=0 in cycle 3 of another run -> outputs cleared immediately and no done pulse.
  - A new start after release completes correctly.
- SHL_ROTATE_EN defined, rotate=1:
  - data_in=0x8000_0000_0000_0001, amount=1 -> result=0x0000_0000_0000_0003, carry_out=1.
  - Same operand with amount=64-bit wrap test amount=63 -> result=0xC000_0000_0000_0000.
